exception_unit: RTL and testbench
=================================

EXCEPTION_UNIT -- requirements
Module: exception_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port IrqPin, input, 1, external interrupt request; level-sensitive, asynchronous to clk.
REQ-004 SHALL have port FiqPin, input, 1, external fast interrupt request; level-sensitive, asynchronous to clk.
REQ-005 SHALL have port IrqFiqMask, input, 2, CPSR {I,F} disable bits: bit1 = I, bit0 = F.
REQ-006 SHALL have port UndefE, input, 1, undefined-instruction request from execute.
REQ-007 SHALL have port SWIE, input, 1, software-interrupt request from execute.
REQ-008 SHALL have port PrefetchAbortE, input, 1, prefetch-abort request from execute.
REQ-009 SHALL have port DataAbortM, input, 1, data-abort request from memory stage.
REQ-010 SHALL have port Exceptions, output, 6, one-hot {FIQ, IRQ, UNDEF, PrefetchAbort, DataAbort, SWI}; drives the CPSR block.
REQ-011 SHALL have port ExceptionFlush, output, 1, pipeline flush request.
REQ-012 SHALL have port ExceptionTaken, output, 1, ExceptionPC valid; PC redirect strobe.
REQ-013 SHALL have port ExceptionPC, output, 32, vector address.
REQ-014 SHALL have port Busy, output, 1, high whenever FSM is not IDLE.

Function
REQ-015 SHALL pass IrqPin and FiqPin each through a two-flop synchronizer, giving IrqS and FiqS with 2-cycle latency.
REQ-016 SHALL form effective requests: irq = IrqS & ~I; fiq = FiqS & ~F; synchronous requests taken as presented.
REQ-017 SHALL select by fixed priority: DataAbort > FIQ > IRQ > PrefetchAbort > Undef > SWI.
REQ-018 SHALL implement FSM states IDLE, FLUSH, TAKE, SETTLE.
REQ-019 SHALL, in IDLE, on any effective request, latch the one-hot winner into a select register and go to FLUSH; otherwise stay in IDLE.
REQ-020 SHALL assert ExceptionFlush for exactly the FLUSH cycle; FLUSH -> TAKE unconditionally.
REQ-021 SHALL, in TAKE, assert the latched one-hot on Exceptions and assert ExceptionTaken for exactly one cycle; TAKE -> SETTLE.
REQ-022 SHALL, in SETTLE, drive all strobes low, giving the CPSR one cycle to set I/F; SETTLE -> IDLE.
REQ-023 SHALL give a latency of 2 cycles from the IDLE request cycle to the TAKE cycle; exceptions are separated by at least 4 cycles.
REQ-024 SHALL ignore synchronous requests (UndefE, SWIE, PrefetchAbortE, DataAbortM) outside IDLE, because they belong to flushed instructions; they are not queued.
REQ-025 SHALL not let a higher-priority request arriving in FLUSH/TAKE/SETTLE preempt the latched selection.
REQ-026 SHALL re-evaluate IRQ/FIQ levels in IDLE; a request still asserted and unmasked after SETTLE is taken again.
REQ-027 SHALL drive ExceptionPC = base + offset: UNDEF 0x04, SWI 0x08, PrefetchAbort 0x0C, DataAbort 0x10, IRQ 0x18, FIQ 0x1C. ExceptionPC holds its value between exceptions.
REQ-028 SHALL keep Exceptions at zero in every cycle except TAKE, and never assert more than one bit.

Reset
REQ-029 SHALL, while reset is high at a clock edge, enter IDLE, clear synchronizers and select register, and set Exceptions=0, ExceptionFlush=0, ExceptionTaken=0, Busy=0, ExceptionPC=base+0x00.
REQ-030 SHALL, on reset in FLUSH/TAKE/SETTLE, abandon the sequence with no further Exceptions pulse.

Configuration
REQ-031 SHALL use macro HIGH_VECTORS_EN: when defined, base = 0xFFFF0000; when undefined, base = 0x00000000.

Verification
REQ-032 SHALL cover: SWIE pulse in IDLE -> ExceptionFlush at +1, Exceptions=6'b000001 and ExceptionPC=0x08 at +2, Busy high for 3 cycles.
REQ-033 SHALL cover: DataAbortM and FiqPin (synced, F=0) in the same IDLE cycle -> Exceptions=6'b000010, ExceptionPC=0x10; FIQ taken after SETTLE -> 6'b100000, 0x1C.
REQ-034 SHALL cover: IrqPin high with I=1 -> no activity for 20 cycles; clear I -> TAKE with 6'b010000, ExceptionPC=0x18 within 1+2 cycles.
REQ-035 SHALL cover: UndefE asserted during FLUSH of a SWI sequence -> only the SWI pulse occurs; Undef is dropped.
REQ-036 SHALL cover: reset asserted in TAKE+0 of PrefetchAbort -> next cycle all outputs 0, ExceptionPC=base, no second pulse.
REQ-037 SHALL cover: with HIGH_VECTORS_EN defined, a PrefetchAbortE request -> ExceptionPC=0xFFFF000C.

Source files
------------

// File: rtl/exception_unit.sv
// Exception sequencer: synchronizes IRQ/FIQ, picks the highest-priority request
// and walks IDLE->FLUSH->TAKE->SETTLE. Define HIGH_VECTORS_EN for the 0xFFFF0000 vector base.
module exception_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        IrqPin,
  input  logic        FiqPin,
  input  logic [1:0]  IrqFiqMask,
  input  logic        UndefE,
  input  logic        SWIE,
  input  logic        PrefetchAbortE,
  input  logic        DataAbortM,
  output logic [5:0]  Exceptions,
  output logic        ExceptionFlush,
  output logic        ExceptionTaken,
  output logic [31:0] ExceptionPC,
  output logic        Busy
);

`ifdef HIGH_VECTORS_EN
  localparam logic [31:0] VEC_BASE = 32'hFFFF_0000;
`else
  localparam logic [31:0] VEC_BASE = 32'h0000_0000;
`endif

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FLUSH  = 2'd1;
  localparam logic [1:0] S_TAKE   = 2'd2;
  localparam logic [1:0] S_SETTLE = 2'd3;

  // One-hot bit positions: {FIQ, IRQ, UNDEF, PrefetchAbort, DataAbort, SWI}
  localparam logic [5:0] EX_SWI  = 6'b000001;
  localparam logic [5:0] EX_DABT = 6'b000010;
  localparam logic [5:0] EX_PABT = 6'b000100;
  localparam logic [5:0] EX_UND  = 6'b001000;
  localparam logic [5:0] EX_IRQ  = 6'b010000;
  localparam logic [5:0] EX_FIQ  = 6'b100000;

  logic [1:0]  state_q, state_d;
  logic [1:0]  irq_sync_q, fiq_sync_q;
  logic [5:0]  sel_q, sel_d;
  logic [31:0] pc_q, pc_d;
  logic        irq_eff, fiq_eff;
  logic [5:0]  winner;
  logic [31:0] winner_offset;

  assign irq_eff = irq_sync_q[1] & ~IrqFiqMask[1];
  assign fiq_eff = fiq_sync_q[1] & ~IrqFiqMask[0];

  always_comb begin
    winner = 6'b000000;
    if (DataAbortM)          winner = EX_DABT;
    else if (fiq_eff)        winner = EX_FIQ;
    else if (irq_eff)        winner = EX_IRQ;
    else if (PrefetchAbortE) winner = EX_PABT;
    else if (UndefE)         winner = EX_UND;
    else if (SWIE)           winner = EX_SWI;
  end

  always_comb begin
    winner_offset = 32'h0000_0000;
    case (winner)
      EX_UND:  winner_offset = 32'h0000_0004;
      EX_SWI:  winner_offset = 32'h0000_0008;
      EX_PABT: winner_offset = 32'h0000_000C;
      EX_DABT: winner_offset = 32'h0000_0010;
      EX_IRQ:  winner_offset = 32'h0000_0018;
      EX_FIQ:  winner_offset = 32'h0000_001C;
      default: winner_offset = 32'h0000_0000;
    endcase
  end

  // Requests are only sampled in IDLE; anything arriving later belongs to flushed work.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE: begin
        if (winner != 6'b000000) begin
          sel_d   = winner;
          pc_d    = VEC_BASE + winner_offset;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH:  state_d = S_TAKE;
      S_TAKE:   state_d = S_SETTLE;
      S_SETTLE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      irq_sync_q <= 2'b00;
      fiq_sync_q <= 2'b00;
      sel_q      <= 6'b000000;
      pc_q       <= VEC_BASE;
    end else begin
      state_q    <= state_d;
      irq_sync_q <= {irq_sync_q[0], IrqPin};
      fiq_sync_q <= {fiq_sync_q[0], FiqPin};
      sel_q      <= sel_d;
      pc_q       <= pc_d;
    end
  end

  assign Exceptions     = (state_q == S_TAKE) ? sel_q : 6'b000000;
  assign ExceptionFlush = (state_q == S_FLUSH);
  assign ExceptionTaken = (state_q == S_TAKE);
  assign Busy           = (state_q != S_IDLE);
  assign ExceptionPC    = pc_q;

endmodule

// File: tb/tb_exception_unit.sv
// Bench for exception_unit: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a cycle-indexed timeline model.
module tb_exception_unit;

`ifdef HIGH_VECTORS_EN
  localparam logic [31:0] BASE = 32'hFFFF_0000;
`else
  localparam logic [31:0] BASE = 32'h0000_0000;
`endif
  localparam int MAXC = 8192;
  localparam int NONE = -100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        IrqPin = 1'b0, FiqPin = 1'b0;
  logic [1:0]  IrqFiqMask = 2'b11;
  logic        UndefE = 1'b0, SWIE = 1'b0, PrefetchAbortE = 1'b0, DataAbortM = 1'b0;
  logic [5:0]  Exceptions;
  logic        ExceptionFlush, ExceptionTaken, Busy;
  logic [31:0] ExceptionPC;

  int total = 0;
  int bad = 0;
  bit chk_on = 0;

  exception_unit dut (
    .clk(clk), .reset(reset), .IrqPin(IrqPin), .FiqPin(FiqPin), .IrqFiqMask(IrqFiqMask),
    .UndefE(UndefE), .SWIE(SWIE), .PrefetchAbortE(PrefetchAbortE), .DataAbortM(DataAbortM),
    .Exceptions(Exceptions), .ExceptionFlush(ExceptionFlush), .ExceptionTaken(ExceptionTaken),
    .ExceptionPC(ExceptionPC), .Busy(Busy)
  );

  always #5 clk = ~clk;

  // Model: per-cycle pin/reset history; an accepted exception at cycle a gives
  // flush at a+1, take at a+2, busy a+1..a+3, and idle again from a+4.
  int          cyc = 0;
  bit          irq_h[MAXC];
  bit          fiq_h[MAXC];
  bit          rst_h[MAXC];
  int          acc = NONE;
  logic [5:0]  win_m = 6'b0;
  logic [31:0] pc_m = BASE;

  function automatic logic [31:0] vec_off(input logic [5:0] code);
    case (code)
      6'b001000: return 32'h04;
      6'b000001: return 32'h08;
      6'b000100: return 32'h0C;
      6'b000010: return 32'h10;
      6'b010000: return 32'h18;
      6'b100000: return 32'h1C;
      default:   return 32'h00;
    endcase
  endfunction

  task automatic model_step();
    bit irq_s, fiq_s, irq_e, fiq_e;
    logic [5:0] code;
    irq_h[cyc] = IrqPin;
    fiq_h[cyc] = FiqPin;
    rst_h[cyc] = reset;
    if (reset) begin
      acc  = NONE;
      pc_m = BASE;
    end else if (cyc - acc >= 4) begin
      irq_s = (cyc >= 2) && irq_h[cyc-2] && !rst_h[cyc-2] && !rst_h[cyc-1];
      fiq_s = (cyc >= 2) && fiq_h[cyc-2] && !rst_h[cyc-2] && !rst_h[cyc-1];
      irq_e = irq_s && !IrqFiqMask[1];
      fiq_e = fiq_s && !IrqFiqMask[0];
      code = 6'b0;
      if (DataAbortM)          code = 6'b000010;
      else if (fiq_e)          code = 6'b100000;
      else if (irq_e)          code = 6'b010000;
      else if (PrefetchAbortE) code = 6'b000100;
      else if (UndefE)         code = 6'b001000;
      else if (SWIE)           code = 6'b000001;
      if (code != 6'b0) begin
        acc   = cyc;
        win_m = code;
        pc_m  = BASE + vec_off(code);
      end
    end
    if (cyc < MAXC - 1) cyc++;
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    int d;
    logic [40:0] got, exp;
    if (chk_on) begin
      d   = cyc - acc;
      exp = {(d >= 1 && d <= 3), (d == 1), (d == 2), ((d == 2) ? win_m : 6'b0), pc_m};
      got = {Busy, ExceptionFlush, ExceptionTaken, Exceptions, ExceptionPC};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL cycle%0d {busy,flush,taken,exc,pc} got=%h exp=%h", cyc, got, exp);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end else begin
      $display("ok   %s = %h", name, got);
    end
  endtask

  task automatic nxt(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset
    nxt(3);
    reset = 1'b0;
    chk_on = 1;
    chk("reset_exc", {26'b0, Exceptions}, 32'h0);
    chk("reset_flush", {31'b0, ExceptionFlush}, 32'h0);
    chk("reset_taken", {31'b0, ExceptionTaken}, 32'h0);
    chk("reset_busy", {31'b0, Busy}, 32'h0);
    chk("reset_pc", ExceptionPC, BASE);

    // SWI with a late UndefE during FLUSH that must be dropped
    SWIE = 1'b1; nxt(); SWIE = 1'b0;
    chk("swi_flush", {31'b0, ExceptionFlush}, 32'h1);
    UndefE = 1'b1; nxt(); UndefE = 1'b0;
    chk("swi_exc", {26'b0, Exceptions}, 32'h01);
    chk("swi_pc", ExceptionPC, BASE + 32'h08);
    chk("swi_taken", {31'b0, ExceptionTaken}, 32'h1);
    nxt();
    chk("swi_settle_busy", {31'b0, Busy}, 32'h1);
    chk("swi_settle_exc", {26'b0, Exceptions}, 32'h0);
    nxt();
    chk("swi_idle_busy", {31'b0, Busy}, 32'h0);
    nxt(3);
    chk("undef_dropped_pc", ExceptionPC, BASE + 32'h08);

    // DataAbort beats a simultaneous FIQ; FIQ is taken after SETTLE
    IrqFiqMask = 2'b10; FiqPin = 1'b1; nxt(2);
    DataAbortM = 1'b1; nxt(); DataAbortM = 1'b0;
    nxt();
    chk("dabt_exc", {26'b0, Exceptions}, 32'h02);
    chk("dabt_pc", ExceptionPC, BASE + 32'h10);
    nxt(2);
    FiqPin = 1'b0; nxt(2);
    chk("fiq_exc", {26'b0, Exceptions}, 32'h20);
    chk("fiq_pc", ExceptionPC, BASE + 32'h1C);
    IrqFiqMask = 2'b11; nxt(6);

    // Masked IRQ stays quiet, then fires once unmasked
    IrqFiqMask = 2'b10; IrqPin = 1'b1;
    for (int i = 0; i < 20; i++) begin
      nxt();
      chk("irq_masked_busy", {31'b0, Busy}, 32'h0);
    end
    IrqFiqMask = 2'b00; nxt(2);
    chk("irq_exc", {26'b0, Exceptions}, 32'h10);
    chk("irq_pc", ExceptionPC, BASE + 32'h18);
    IrqPin = 1'b0; IrqFiqMask = 2'b11; nxt(6);

    // Reset during TAKE of a prefetch abort
    PrefetchAbortE = 1'b1; nxt(); PrefetchAbortE = 1'b0; nxt();
    chk("pabt_exc", {26'b0, Exceptions}, 32'h04);
    chk("pabt_pc", ExceptionPC, BASE + 32'h0C);
    reset = 1'b1; nxt(); reset = 1'b0;
    chk("pabt_rst_exc", {26'b0, Exceptions}, 32'h0);
    chk("pabt_rst_busy", {31'b0, Busy}, 32'h0);
    chk("pabt_rst_pc", ExceptionPC, BASE);
    for (int i = 0; i < 4; i++) begin
      nxt();
      chk("pabt_no_second", {31'b0, ExceptionTaken}, 32'h0);
    end

    // Randomized traffic, checked each cycle by the model
    for (int i = 0; i < 3000; i++) begin
      reset          = ($urandom_range(99) == 0);
      UndefE         = ($urandom_range(9) == 0);
      SWIE           = ($urandom_range(9) == 0);
      PrefetchAbortE = ($urandom_range(11) == 0);
      DataAbortM     = ($urandom_range(13) == 0);
      if ($urandom_range(15) == 0) IrqPin = ~IrqPin;
      if ($urandom_range(15) == 0) FiqPin = ~FiqPin;
      if ($urandom_range(7) == 0)  IrqFiqMask = 2'($urandom_range(3));
      nxt();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
